debounce_bank: RTL
==================

Name: debounce_bank

Overview:
Parametrised multi-channel successor to the single push-button debouncer, for the lift's full set of car and landing call buttons. Each channel synchronises its raw button input and filters it against a shared slow reference strobe, requiring a programmable count of consecutive agreeing samples. Each channel outputs a clean level, one-cycle press and release pulses, and a long-press hold flag. The block sits between the button pads and the call-request and control logic.

Parameters:
NCH, 8, number of independent button channels (>=1)
SAMPLES, 3, consecutive slowref samples required to accept a level change (>=2)
HOLD_TICKS, 16, slowref strobes a button must stay active before hold asserts (>=1)
IDLE_LEVEL, 1, released (idle) level of the buttons; clean resets to this value; active level is !IDLE_LEVEL
SYNC_STAGES, 2, input synchroniser depth in clk flops (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
slowref  input  1  8-32 Hz sample strobe, one clk wide, shared by all channels
pbsig  input  NCH  raw push-button inputs, asynchronous to clk
clean  output  NCH  debounced level per channel
press  output  NCH  one-clk pulse when clean goes idle->active
release  output  NCH  one-clk pulse when clean goes active->idle
hold  output  NCH  level; channel active for HOLD_TICKS strobes

Behaviour:
- Reset (async, active-high): synchroniser flops = IDLE_LEVEL; clean = all IDLE_LEVEL; press, release, hold = 0; all counters = 0. Outputs reach these values immediately on reset assertion, without waiting for a clk edge.
- Synchroniser: each pbsig bit passes through SYNC_STAGES flops on every clk, independent of slowref. The synchroniser output is s[i].
- Per-channel sample counter, width clog2(SAMPLES). It updates only on clk edges where slowref=1:
  - s[i]==clean[i]: counter <= 0.
  - s[i]!=clean[i] and counter==SAMPLES-1: clean[i] <= s[i]; counter <= 0.
  - Otherwise: counter++.
- A level change is accepted only after SAMPLES consecutive disagreeing strobes. A single agreeing strobe restarts the count.
- Latency from a pbsig change to clean: SYNC_STAGES clk plus SAMPLES strobes. Minimum with slowref tied high: SYNC_STAGES+SAMPLES clk.
- press[i] and release[i] are registered on the same edge that updates clean[i]. Each is high for exactly one clk. They never assert together, and never without a clean change.
- Hold counter, width clog2(HOLD_TICKS+1):
  - Cleared while clean[i] is idle.
  - While clean[i] is active and hold[i]=0, it increments on each slowref. The strobe that causes the press does not count.
  - hold[i] is set on the strobe where the counter reaches HOLD_TICKS. The counter then saturates.
  - hold[i] clears on the same edge that clean[i] returns idle, coincident with release[i].
- When slowref=0, clean, the counters and hold are stable; press and release are 0.
- Channels are fully independent. Simultaneous events on any number of channels produce simultaneous pulses.
- slowref held high continuously is legal: every clk is treated as a sample.
- Reset mid-count discards the partial count. After reset deassertion, a full SAMPLES-strobe qualification is required again.
- Pins not tied off are don't-care beyond the synchroniser. There is no combinational path from pbsig to any output.

Test Plan:
All tests use NCH=4, SAMPLES=3, HOLD_TICKS=4, IDLE_LEVEL=1, SYNC_STAGES=2, with slowref pulsed every 4 clk.
1. Reset check: assert reset with pbsig=4'b1111 -> clean=4'b1111, press=release=hold=4'b0000. Hold reset high and drive pbsig=0 -> outputs unchanged.
2. Clean press: drive pbsig[0]=0 and hold it -> clean[0] falls on the 3rd strobe after s[0]=0. press[0] is high for exactly 1 clk on that edge. clean[3:1] stays 3'b111 and release=0.
3. Glitch rejection: pbsig[1]=0 for 2 strobes, then 1 for 1 strobe, then 0 for 2 strobes -> clean[1] stays 1 and press[1] never asserts.
4. Hold and release: hold pbsig[2]=0 -> press[2] at strobe 3 and hold[2] rises at strobe 7. Then set pbsig[2]=1 -> after 3 strobes clean[2]=1, with release[2] pulsed for 1 clk and hold[2] falling on the same edge.
5. Simultaneous channels: drop pbsig[0] and pbsig[3] on the same clk -> press=4'b1001 in a single cycle. The later release of both gives release=4'b1001 in a single cycle.
6. Reset mid-operation: pbsig[1]=0 for 2 strobes, then pulse reset for 1 clk -> outputs go idle asynchronously. With pbsig[1] still 0, clean[1] falls only on the 3rd strobe after reset deassertion.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchronise, slowref-qualified debounce, press/release pulses, long-press hold
module debounce_bank #(
  parameter int NCH         = 8,
  parameter int SAMPLES     = 3,
  parameter int HOLD_TICKS  = 16,
  parameter int IDLE_LEVEL  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           slowref,
  input  logic [NCH-1:0] pbsig,
  output logic [NCH-1:0] clean,
  output logic [NCH-1:0] press,
  output logic [NCH-1:0] rel,
  output logic [NCH-1:0] hold
);
  localparam int   SW   = $clog2(SAMPLES);
  localparam int   HW   = $clog2(HOLD_TICKS + 1);
  localparam logic IDLE = IDLE_LEVEL[0];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sr;
    logic [SW-1:0]          scnt;
    logic [HW-1:0]          hcnt;
    logic                   c, p, r, h, s, flip, nc;
    assign s    = sr[SYNC_STAGES-1];
    assign flip = slowref && s != c && scnt == SW'(SAMPLES - 1);
    assign nc   = flip ? s : c;
    assign clean[i] = c;
    assign press[i] = p;
    assign rel[i]   = r;
    assign hold[i]  = h;
    // the press strobe itself is not counted: c is still idle on that edge
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        sr   <= {SYNC_STAGES{IDLE}};
        scnt <= '0;
        hcnt <= '0;
        c    <= IDLE;
        p    <= 1'b0;
        r    <= 1'b0;
        h    <= 1'b0;
      end else begin
        sr <= {sr[SYNC_STAGES-2:0], pbsig[i]};
        p  <= flip && s != IDLE;
        r  <= flip && s == IDLE;
        if (slowref) begin
          c    <= nc;
          scnt <= (s == c || flip) ? '0 : scnt + 1'b1;
          hcnt <= nc == IDLE ? '0 : (c != IDLE && !h) ? hcnt + 1'b1 : hcnt;
          h    <= nc != IDLE && (h || (c != IDLE && hcnt == HW'(HOLD_TICKS - 1)));
        end
      end
  end
endmodule
